// File: rtl/core_control_fsm_pkg.sv
// -----------------------------------------------------------------------------
// core_control_fsm_pkg
// Shared types and constants for the RV32I multi-cycle control unit:
// ALU operand/operation selects, immediate formats, write-back and PC source
// selects, FSM states, instruction classes, the decoded control word and the
// RV32I opcode/funct encodings. Also holds the branch-resolution helper.
// -----------------------------------------------------------------------------
package core_control_fsm_pkg;

    typedef enum logic [1:0] {
        OPERAND_RS1,
        OPERAND_RS2,
        OPERAND_IMM,
        OPERAND_PC
    } alu_operand_t;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUBTRACT,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_LESS_THAN,
        ALU_LESS_THAN_UNSIGNED
    } alu_operation_t;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_type_t;

    typedef enum logic [1:0] {
        WB_ALU,
        WB_MEM,
        WB_PC_PLUS4
    } wb_select_t;

    typedef enum logic [1:0] {
        PC_SEL_PLUS4,
        PC_SEL_ALU,
        PC_SEL_ALU_ALIGNED
    } pc_select_t;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_MEMORY,
        ST_WRITEBACK,
        ST_BRANCH,
        ST_TRAP
    } fsm_state_t;

    typedef enum logic [3:0] {
        CLS_ALU,
        CLS_LUI,
        CLS_AUIPC,
        CLS_JAL,
        CLS_JALR,
        CLS_BRANCH,
        CLS_LOAD,
        CLS_STORE,
        CLS_FENCE
    } instr_class_t;

    typedef struct packed {
        alu_operand_t   a_sel;
        alu_operand_t   b_sel;
        alu_operation_t op;
        imm_type_t      imm;
        instr_class_t   cls;
        logic           legal;
    } ctrl_word_t;

    // Opcodes
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // funct3 for OP / OP-IMM
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // funct3 for branches
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // funct7
    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // ADDI x0,x0,0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Branch outcome from the compare result produced in EXECUTE.
    // EQ/NE use the subtract result; the LT variants use bit 0 of the
    // set-less-than result.
    function automatic logic branch_taken(input logic [2:0]  funct3,
                                          input logic [31:0] alu_result);
        logic taken;
        taken = 1'b0;
        case (funct3)
            F3_BEQ:           taken = (alu_result == 32'd0);
            F3_BNE:           taken = (alu_result != 32'd0);
            F3_BLT, F3_BLTU:  taken = alu_result[0];
            F3_BGE, F3_BGEU:  taken = ~alu_result[0];
            default:          taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/core_control_fsm_decoder.sv
// -----------------------------------------------------------------------------
// core_control_fsm_decoder
// Combinational RV32I decoder: maps an instruction word to the control word
// (ALU operand selects, ALU operation, immediate format, instruction class and
// legality). ECALL/EBREAK and every SYSTEM encoding are reported illegal.
//
// Ports:
//   i_instr  in   32           instruction word
//   o_ctrl   out  ctrl_word_t  decoded control word
// -----------------------------------------------------------------------------
module core_control_fsm_decoder
    import core_control_fsm_pkg::*;
(
    input  logic [31:0] i_instr,
    output ctrl_word_t  o_ctrl
);

    logic [6:0]     w_opcode;
    logic [2:0]     w_funct3;
    logic [6:0]     w_funct7;
    alu_operation_t w_arith_op;
    ctrl_word_t     w_ctrl;
    logic           w_unused_bits;

    assign w_opcode = i_instr[6:0];
    assign w_funct3 = i_instr[14:12];
    assign w_funct7 = i_instr[31:25];

    // Register/immediate fields are consumed by the datapath, not here.
    assign w_unused_bits = ^i_instr[24:7];

    // funct3 -> ALU operation shared by OP and OP-IMM (funct7 refines later)
    always_comb begin
        w_arith_op = ALU_ADD;
        case (w_funct3)
            F3_ADD_SUB: w_arith_op = ALU_ADD;
            F3_SLL:     w_arith_op = ALU_SLL;
            F3_SLT:     w_arith_op = ALU_LESS_THAN;
            F3_SLTU:    w_arith_op = ALU_LESS_THAN_UNSIGNED;
            F3_XOR:     w_arith_op = ALU_XOR;
            F3_SRL_SRA: w_arith_op = ALU_SRL;
            F3_OR:      w_arith_op = ALU_OR;
            F3_AND:     w_arith_op = ALU_AND;
            default:    w_arith_op = ALU_ADD;
        endcase
    end

    always_comb begin
        w_ctrl.a_sel = OPERAND_RS1;
        w_ctrl.b_sel = OPERAND_RS1;
        w_ctrl.op    = ALU_ADD;
        w_ctrl.imm   = IMM_I;
        w_ctrl.cls   = CLS_ALU;
        w_ctrl.legal = 1'b0;

        case (w_opcode)
            OPC_OP: begin
                w_ctrl.b_sel = OPERAND_RS2;
                if (w_funct7 == F7_ZERO) begin
                    w_ctrl.op    = w_arith_op;
                    w_ctrl.legal = 1'b1;
                end else if (w_funct7 == F7_ALT && w_funct3 == F3_ADD_SUB) begin
                    w_ctrl.op    = ALU_SUBTRACT;
                    w_ctrl.legal = 1'b1;
                end else if (w_funct7 == F7_ALT && w_funct3 == F3_SRL_SRA) begin
                    w_ctrl.op    = ALU_SRA;
                    w_ctrl.legal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                w_ctrl.b_sel = OPERAND_IMM;
                w_ctrl.op    = w_arith_op;
                // Shift-immediates reuse imm[11:5] as funct7.
                if (w_funct3 == F3_SLL) begin
                    w_ctrl.legal = (w_funct7 == F7_ZERO);
                end else if (w_funct3 == F3_SRL_SRA) begin
                    if (w_funct7 == F7_ZERO) begin
                        w_ctrl.legal = 1'b1;
                    end else if (w_funct7 == F7_ALT) begin
                        w_ctrl.op    = ALU_SRA;
                        w_ctrl.legal = 1'b1;
                    end
                end else begin
                    w_ctrl.legal = 1'b1;
                end
            end
            OPC_LUI: begin
                w_ctrl.a_sel = OPERAND_IMM;
                w_ctrl.b_sel = OPERAND_IMM;
                w_ctrl.op    = ALU_OR;
                w_ctrl.imm   = IMM_U;
                w_ctrl.cls   = CLS_LUI;
                w_ctrl.legal = 1'b1;
            end
            OPC_AUIPC: begin
                w_ctrl.a_sel = OPERAND_PC;
                w_ctrl.b_sel = OPERAND_IMM;
                w_ctrl.imm   = IMM_U;
                w_ctrl.cls   = CLS_AUIPC;
                w_ctrl.legal = 1'b1;
            end
            OPC_JAL: begin
                w_ctrl.a_sel = OPERAND_PC;
                w_ctrl.b_sel = OPERAND_IMM;
                w_ctrl.imm   = IMM_J;
                w_ctrl.cls   = CLS_JAL;
                w_ctrl.legal = 1'b1;
            end
            OPC_JALR: begin
                w_ctrl.b_sel = OPERAND_IMM;
                w_ctrl.cls   = CLS_JALR;
                w_ctrl.legal = (w_funct3 == 3'b000);
            end
            OPC_BRANCH: begin
                w_ctrl.b_sel = OPERAND_RS2;
                w_ctrl.imm   = IMM_B;
                w_ctrl.cls   = CLS_BRANCH;
                case (w_funct3)
                    F3_BEQ, F3_BNE: begin
                        w_ctrl.op    = ALU_SUBTRACT;
                        w_ctrl.legal = 1'b1;
                    end
                    F3_BLT, F3_BGE: begin
                        w_ctrl.op    = ALU_LESS_THAN;
                        w_ctrl.legal = 1'b1;
                    end
                    F3_BLTU, F3_BGEU: begin
                        w_ctrl.op    = ALU_LESS_THAN_UNSIGNED;
                        w_ctrl.legal = 1'b1;
                    end
                    default: w_ctrl.legal = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                w_ctrl.b_sel = OPERAND_IMM;
                w_ctrl.cls   = CLS_LOAD;
                // LB, LH, LW, LBU, LHU
                w_ctrl.legal = (w_funct3 == 3'b000) || (w_funct3 == 3'b001) ||
                               (w_funct3 == 3'b010) || (w_funct3 == 3'b100) ||
                               (w_funct3 == 3'b101);
            end
            OPC_STORE: begin
                w_ctrl.b_sel = OPERAND_IMM;
                w_ctrl.imm   = IMM_S;
                w_ctrl.cls   = CLS_STORE;
                // SB, SH, SW
                w_ctrl.legal = (w_funct3 == 3'b000) || (w_funct3 == 3'b001) ||
                               (w_funct3 == 3'b010);
            end
            OPC_MISC_MEM: begin
                w_ctrl.cls   = CLS_FENCE;
                w_ctrl.legal = (w_funct3 == 3'b000);
            end
            // ECALL/EBREAK trap; no CSRs in this core, so all of SYSTEM is illegal.
            OPC_SYSTEM: w_ctrl.legal = 1'b0;
            default:    w_ctrl.legal = 1'b0;
        endcase
    end

    assign o_ctrl = w_ctrl;

endmodule

// File: rtl/core_control_fsm.sv
// -----------------------------------------------------------------------------
// core_control_fsm
// Multi-cycle RV32I control unit. Fetches, decodes and sequences the shared
// ALU, register file, PC and data memory over FETCH/DECODE/EXECUTE/MEMORY/
// WRITEBACK, with a BRANCH state for taken branches and a sticky TRAP state
// for illegal instructions and bus timeouts.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   instr_req/instr_ready/rdata     instruction fetch handshake
//   data_req/data_we/data_ready     data access handshake (address = alu_result)
//   alu_result                      ALU output (branch compare in EXECUTE)
//   alu_operand_a/b_select,
//   alu_operation, imm_select       ALU / immediate control
//   instr                           latched instruction register
//   rf_we, wb_select                register-file write control
//   pc_we, pc_select                PC update control
//   illegal_instr, bus_error        sticky trap causes
// -----------------------------------------------------------------------------
module core_control_fsm
    import core_control_fsm_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    output logic           instr_req,
    input  logic           instr_ready,
    input  logic [31:0]    instr_rdata,
    output logic           data_req,
    output logic           data_we,
    input  logic           data_ready,
    input  logic [31:0]    alu_result,
    output alu_operand_t   alu_operand_a_select,
    output alu_operand_t   alu_operand_b_select,
    output alu_operation_t alu_operation,
    output imm_type_t      imm_select,
    output logic [31:0]    instr,
    output logic           rf_we,
    output wb_select_t     wb_select,
    output logic           pc_we,
    output pc_select_t     pc_select,
    output logic           illegal_instr,
    output logic           bus_error
);

    localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

    fsm_state_t       r_state;
    fsm_state_t       w_state_next;
    logic [31:0]      r_instr;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_wait_next;
    logic [CNT_W-1:0] w_wait_inc;
    logic             w_timeout;
    logic             r_illegal;
    logic             r_bus_error;
    logic             w_latch_instr;
    logic             w_set_illegal;
    logic             w_set_bus_error;
    logic             w_rd_nonzero;
    ctrl_word_t       w_ctrl;

    core_control_fsm_decoder u_decoder (
        .i_instr (r_instr),
        .o_ctrl  (w_ctrl)
    );

    assign w_rd_nonzero = (r_instr[11:7] != 5'd0);
    assign w_wait_inc   = r_wait_cnt + 1'b1;
    // The request cycle that would make the count reach MAX_WAIT is the last one.
    assign w_timeout    = (MAX_WAIT != 0) && (w_wait_inc == WAIT_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_FETCH;
            r_instr     <= NOP_INSTR;
            r_wait_cnt  <= '0;
            r_illegal   <= 1'b0;
            r_bus_error <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_wait_cnt  <= w_wait_next;
            if (w_latch_instr) begin
                r_instr <= instr_rdata;
            end
            r_illegal   <= r_illegal | w_set_illegal;
            r_bus_error <= r_bus_error | w_set_bus_error;
        end
    end

    always_comb begin
        w_state_next         = r_state;
        w_wait_next          = r_wait_cnt;
        w_latch_instr        = 1'b0;
        w_set_illegal        = 1'b0;
        w_set_bus_error      = 1'b0;
        instr_req            = 1'b0;
        data_req             = 1'b0;
        data_we              = 1'b0;
        rf_we                = 1'b0;
        pc_we                = 1'b0;
        wb_select            = WB_ALU;
        pc_select            = PC_SEL_PLUS4;
        alu_operand_a_select = OPERAND_RS1;
        alu_operand_b_select = OPERAND_RS1;
        alu_operation        = ALU_ADD;
        imm_select           = w_ctrl.imm;

        case (r_state)
            ST_FETCH: begin
                instr_req = 1'b1;
                if (instr_ready) begin
                    w_latch_instr = 1'b1;
                    w_wait_next   = '0;
                    w_state_next  = ST_DECODE;
                end else if (w_timeout) begin
                    w_wait_next     = '0;
                    w_set_bus_error = 1'b1;
                    w_state_next    = ST_TRAP;
                end else if (MAX_WAIT != 0) begin
                    w_wait_next = w_wait_inc;
                end
            end

            ST_DECODE: begin
                if (w_ctrl.legal) begin
                    w_state_next = ST_EXECUTE;
                end else begin
                    w_set_illegal = 1'b1;
                    w_state_next  = ST_TRAP;
                end
            end

            ST_EXECUTE: begin
                alu_operand_a_select = w_ctrl.a_sel;
                alu_operand_b_select = w_ctrl.b_sel;
                alu_operation        = w_ctrl.op;
                case (w_ctrl.cls)
                    CLS_LOAD, CLS_STORE: w_state_next = ST_MEMORY;
                    CLS_BRANCH: begin
                        if (branch_taken(r_instr[14:12], alu_result)) begin
                            w_state_next = ST_BRANCH;
                        end else begin
                            pc_we        = 1'b1;
                            pc_select    = PC_SEL_PLUS4;
                            w_state_next = ST_FETCH;
                        end
                    end
                    default: w_state_next = ST_WRITEBACK;
                endcase
            end

            ST_MEMORY: begin
                // Selects held so alu_result (the address) stays valid.
                alu_operand_a_select = w_ctrl.a_sel;
                alu_operand_b_select = w_ctrl.b_sel;
                alu_operation        = w_ctrl.op;
                data_req             = 1'b1;
                data_we              = (w_ctrl.cls == CLS_STORE);
                if (data_ready) begin
                    w_wait_next = '0;
                    if (w_ctrl.cls == CLS_STORE) begin
                        pc_we        = 1'b1;
                        pc_select    = PC_SEL_PLUS4;
                        w_state_next = ST_FETCH;
                    end else begin
                        w_state_next = ST_WRITEBACK;
                    end
                end else if (w_timeout) begin
                    w_wait_next     = '0;
                    w_set_bus_error = 1'b1;
                    w_state_next    = ST_TRAP;
                end else if (MAX_WAIT != 0) begin
                    w_wait_next = w_wait_inc;
                end
            end

            ST_WRITEBACK: begin
                alu_operand_a_select = w_ctrl.a_sel;
                alu_operand_b_select = w_ctrl.b_sel;
                alu_operation        = w_ctrl.op;
                pc_we                = 1'b1;
                rf_we                = w_rd_nonzero && (w_ctrl.cls != CLS_FENCE);
                case (w_ctrl.cls)
                    CLS_LOAD: wb_select = WB_MEM;
                    CLS_JAL: begin
                        wb_select = WB_PC_PLUS4;
                        pc_select = PC_SEL_ALU;
                    end
                    CLS_JALR: begin
                        wb_select = WB_PC_PLUS4;
                        pc_select = PC_SEL_ALU_ALIGNED;
                    end
                    default: wb_select = WB_ALU;
                endcase
                w_state_next = ST_FETCH;
            end

            ST_BRANCH: begin
                alu_operand_a_select = OPERAND_PC;
                alu_operand_b_select = OPERAND_IMM;
                alu_operation        = ALU_ADD;
                imm_select           = IMM_B;
                pc_we                = 1'b1;
                pc_select            = PC_SEL_ALU;
                w_state_next         = ST_FETCH;
            end

            // Dead end until reset; late ready strobes are ignored.
            ST_TRAP: w_state_next = ST_TRAP;

            default: w_state_next = ST_FETCH;
        endcase
    end

    assign instr         = r_instr;
    assign illegal_instr = r_illegal;
    assign bus_error     = r_bus_error;

endmodule
